// File: rtl/trace_chk_pkg.sv
// Shared types for the write-back trace checker: golden entry layout, checker state
// and the byte-lane mask helper used by the optional masked wdata compare.
package trace_chk_pkg;

    localparam int TRACE_ENTRY_W = 69;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        ERROR = 2'd1,
        DONE  = 2'd2
    } chk_state_t;

    // Expands the four byte write enables into a 32-bit lane mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] we);
        logic [31:0] m;
        m = 32'h0000_0000;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                m[8*b +: 8] = 8'hFF;
            end else begin
                m[8*b +: 8] = 8'h00;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of golden trace entries; combinational head, registered level
// with an extra bit so that full and empty are distinguishable.
module trace_fifo
    import trace_chk_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  trace_entry_t           din,
    output trace_entry_t           dout,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [TRACE_ENTRY_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]            wr_ptr_r;
    logic [AW-1:0]            rd_ptr_r;
    logic                     push_ok_s;
    logic                     pop_ok_s;

    assign push_ok_s = push && (level != LW'(DEPTH));
    assign pop_ok_s  = pop && (level != LW'(0));
    assign dout      = trace_entry_t'(mem_r[rd_ptr_r]);

    // Storage array; contents are meaningless until the level says otherwise.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= TRACE_ENTRY_W'(din);
        end
    end

    // Pointers wrap naturally modulo DEPTH; level tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level    <= LW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/wb_trace_checker.sv
// Compares each architectural register write-back against a golden trace FIFO and
// latches the first divergence. Define TRACE_CHK_BYTE_MASK_EN to compare only written bytes.
module wb_trace_checker
    import trace_chk_pkg::*;
#(
    parameter int          DEPTH  = 16,
    parameter logic [31:0] END_PC = 32'h1c00_0100,
    parameter int          CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            wb_pc,
    input  logic [3:0]             wb_rf_we,
    input  logic [4:0]             wb_rf_wnum,
    input  logic [31:0]            wb_rf_wdata,
    input  logic                   ref_valid,
    output logic                   ref_ready,
    input  logic [31:0]            ref_pc,
    input  logic [4:0]             ref_wnum,
    input  logic [31:0]            ref_wdata,
    output logic                   chk_done,
    output logic                   chk_error,
    output logic                   err_underflow,
    output logic [31:0]            err_pc,
    output logic [4:0]             err_exp_wnum,
    output logic [31:0]            err_exp_wdata,
    output logic [4:0]             err_act_wnum,
    output logic [31:0]            err_act_wdata,
    output logic [CNT_W-1:0]       match_cnt,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int LW = $clog2(DEPTH) + 1;

    chk_state_t   state_r;
    trace_entry_t head_s;
    trace_entry_t push_entry_s;
    logic [LW-1:0] level_s;
    logic [31:0]  wdata_mask_s;
    logic         fifo_empty_s;
    logic         event_s;
    logic         push_s;
    logic         pop_s;
    logic         match_s;

    assign push_entry_s = '{pc: ref_pc, wnum: ref_wnum, wdata: ref_wdata};
    assign fifo_empty_s = (level_s == LW'(0));
    assign fifo_level   = level_s;

    // Ready comes only from registered state and level, so a pop cannot free a slot in the same cycle.
    assign ref_ready = (state_r == RUN) && (level_s < LW'(DEPTH));
    assign push_s    = ref_valid && ref_ready;
    assign event_s   = (state_r == RUN) && (|wb_rf_we) && (wb_rf_wnum != 5'd0);
    assign pop_s     = event_s && !fifo_empty_s;

`ifdef TRACE_CHK_BYTE_MASK_EN
    assign wdata_mask_s = byte_mask(wb_rf_we);
`else
    assign wdata_mask_s = 32'hFFFF_FFFF;
`endif

    // Combinational compare of the live event against the FIFO head.
    always_comb begin
        match_s = 1'b0;
        if ((head_s.pc == wb_pc) && (head_s.wnum == wb_rf_wnum) &&
            (((head_s.wdata ^ wb_rf_wdata) & wdata_mask_s) == 32'h0000_0000)) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (push_entry_s),
        .dout  (head_s),
        .level (level_s)
    );

    // Checker FSM with first-failure capture and saturating match counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= RUN;
            chk_done      <= 1'b0;
            chk_error     <= 1'b0;
            err_underflow <= 1'b0;
            err_pc        <= 32'h0000_0000;
            err_exp_wnum  <= 5'd0;
            err_exp_wdata <= 32'h0000_0000;
            err_act_wnum  <= 5'd0;
            err_act_wdata <= 32'h0000_0000;
            match_cnt     <= CNT_W'(0);
        end else begin
            case (state_r)
                RUN: begin
                    if (event_s) begin
                        if (fifo_empty_s) begin
                            state_r       <= ERROR;
                            chk_error     <= 1'b1;
                            err_underflow <= 1'b1;
                            err_pc        <= wb_pc;
                            err_exp_wnum  <= 5'd0;
                            err_exp_wdata <= 32'h0000_0000;
                            err_act_wnum  <= wb_rf_wnum;
                            err_act_wdata <= wb_rf_wdata;
                        end else if (!match_s) begin
                            state_r       <= ERROR;
                            chk_error     <= 1'b1;
                            err_pc        <= wb_pc;
                            err_exp_wnum  <= head_s.wnum;
                            err_exp_wdata <= head_s.wdata;
                            err_act_wnum  <= wb_rf_wnum;
                            err_act_wdata <= wb_rf_wdata;
                        end else begin
                            if (match_cnt != {CNT_W{1'b1}}) begin
                                match_cnt <= match_cnt + CNT_W'(1);
                            end else begin
                                match_cnt <= match_cnt;
                            end
                            if (wb_pc == END_PC) begin
                                state_r  <= DONE;
                                chk_done <= 1'b1;
                            end else begin
                                state_r <= RUN;
                            end
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                ERROR: state_r <= ERROR;
                DONE:  state_r <= DONE;
                default: begin
                    state_r   <= ERROR;
                    chk_error <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_trace_checker.sv
// Self-checking bench for wb_trace_checker: directed scenarios plus randomized sessions,
// all compared against a queue-based model of the golden-trace rules.
module tb_wb_trace_checker;

    localparam int          DEPTH  = 16;
    localparam logic [31:0] END_PC = 32'h1c00_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_pc;
    logic [3:0]  wb_rf_we;
    logic [4:0]  wb_rf_wnum;
    logic [31:0] wb_rf_wdata;
    logic        ref_valid;
    logic        ref_ready;
    logic [31:0] ref_pc;
    logic [4:0]  ref_wnum;
    logic [31:0] ref_wdata;
    logic        chk_done;
    logic        chk_error;
    logic        err_underflow;
    logic [31:0] err_pc;
    logic [4:0]  err_exp_wnum;
    logic [31:0] err_exp_wdata;
    logic [4:0]  err_act_wnum;
    logic [31:0] err_act_wdata;
    logic [31:0] match_cnt;
    logic [4:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wn;
        logic [31:0] wd;
    } ent_t;

    ent_t        q[$];
    bit          m_err, m_done, m_uf;
    logic [31:0] m_epc, m_ewd, m_awd, m_cnt;
    logic [4:0]  m_ewn, m_awn;

    wb_trace_checker #(.DEPTH(DEPTH), .END_PC(END_PC), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .wb_pc(wb_pc), .wb_rf_we(wb_rf_we), .wb_rf_wnum(wb_rf_wnum), .wb_rf_wdata(wb_rf_wdata),
        .ref_valid(ref_valid), .ref_ready(ref_ready),
        .ref_pc(ref_pc), .ref_wnum(ref_wnum), .ref_wdata(ref_wdata),
        .chk_done(chk_done), .chk_error(chk_error), .err_underflow(err_underflow),
        .err_pc(err_pc), .err_exp_wnum(err_exp_wnum), .err_exp_wdata(err_exp_wdata),
        .err_act_wnum(err_act_wnum), .err_act_wdata(err_act_wdata),
        .match_cnt(match_cnt), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return !m_err && !m_done && (q.size() < DEPTH);
    endfunction

    function automatic bit wd_ok(input logic [31:0] exp, input logic [31:0] act, input logic [3:0] we);
`ifdef TRACE_CHK_BYTE_MASK_EN
        for (int b = 0; b < 4; b++)
            if (we[b] && (exp[8*b +: 8] != act[8*b +: 8])) return 1'b0;
        return 1'b1;
`else
        return exp == act;
`endif
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_edge();
        bit   acc;
        ent_t h;
        acc = ref_valid && m_ready();
        if (reset) begin
            q.delete();
            m_err = 0; m_done = 0; m_uf = 0; m_cnt = 0;
            m_epc = 0; m_ewn = 0; m_ewd = 0; m_awn = 0; m_awd = 0;
            return;
        end
        if (!m_err && !m_done && (wb_rf_we != 4'd0) && (wb_rf_wnum != 5'd0)) begin
            if (q.size() == 0) begin
                m_err = 1; m_uf = 1; m_epc = wb_pc; m_ewn = 0; m_ewd = 0;
                m_awn = wb_rf_wnum; m_awd = wb_rf_wdata;
            end else begin
                h = q.pop_front();
                if (h.pc == wb_pc && h.wn == wb_rf_wnum && wd_ok(h.wd, wb_rf_wdata, wb_rf_we)) begin
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                    if (wb_pc == END_PC) m_done = 1;
                end else begin
                    m_err = 1; m_epc = wb_pc; m_ewn = h.wn; m_ewd = h.wd;
                    m_awn = wb_rf_wnum; m_awd = wb_rf_wdata;
                end
            end
        end
        if (acc) q.push_back('{pc: ref_pc, wn: ref_wnum, wd: ref_wdata});
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_ready"}, ref_ready, m_ready());
        chk({tag, "_level"}, fifo_level, q.size());
        chk({tag, "_done"}, chk_done, m_done);
        chk({tag, "_error"}, chk_error, m_err);
        chk({tag, "_uflow"}, err_underflow, m_uf);
        chk({tag, "_epc"}, err_pc, m_epc);
        chk({tag, "_expwn"}, err_exp_wnum, m_ewn);
        chk({tag, "_expwd"}, err_exp_wdata, m_ewd);
        chk({tag, "_actwn"}, err_act_wnum, m_awn);
        chk({tag, "_actwd"}, err_act_wdata, m_awd);
        chk({tag, "_cnt"}, match_cnt, m_cnt);
    endtask

    task automatic step(input string tag, input logic v, input logic [31:0] rpc, input logic [4:0] rwn,
                        input logic [31:0] rwd, input logic [3:0] we, input logic [31:0] pc,
                        input logic [4:0] wn, input logic [31:0] wd);
        ref_valid = v; ref_pc = rpc; ref_wnum = rwn; ref_wdata = rwd;
        wb_rf_we = we; wb_pc = pc; wb_rf_wnum = wn; wb_rf_wdata = wd;
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic push(input string tag, input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
        step(tag, 1'b1, pc, wn, wd, 4'd0, 32'd0, 5'd0, 32'd0);
    endtask

    task automatic ev(input string tag, input logic [3:0] we, input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
        step(tag, 1'b0, 32'd0, 5'd0, 32'd0, we, pc, wn, wd);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        step(tag, 1'b0, 32'd0, 5'd0, 32'd0, 4'd0, 32'd0, 5'd0, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        ent_t gl[20];
        int   pi, ei;
        reset = 1'b1; ref_valid = 1'b0; ref_pc = 0; ref_wnum = 0; ref_wdata = 0;
        wb_pc = 0; wb_rf_we = 0; wb_rf_wnum = 0; wb_rf_wdata = 0;
        @(negedge clk);
        do_reset("rst");
        chk("rst_ready1", ref_ready, 1'b1);
        chk("rst_level0", fifo_level, 5'd0);

        // 1: three matching writes
        push("t1p", 32'h1c00_0000, 5'd1, 32'd5);
        push("t1p", 32'h1c00_0004, 5'd2, 32'd7);
        push("t1p", 32'h1c00_0008, 5'd3, 32'd9);
        ev("t1e", 4'hF, 32'h1c00_0000, 5'd1, 32'd5);
        ev("t1e", 4'hF, 32'h1c00_0004, 5'd2, 32'd7);
        ev("t1e", 4'hF, 32'h1c00_0008, 5'd3, 32'd9);
        chk("t1_cnt3", match_cnt, 32'd3);
        chk("t1_noerr", chk_error, 1'b0);
        chk("t1_lvl0", fifo_level, 5'd0);

        // 2: wdata mismatch is captured once, later events ignored
        do_reset("t2r");
        push("t2p", 32'h1c00_0004, 5'd2, 32'd7);
        ev("t2e", 4'hF, 32'h1c00_0004, 5'd2, 32'd8);
        chk("t2_err", chk_error, 1'b1);
        chk("t2_epc", err_pc, 32'h1c00_0004);
        chk("t2_exp", err_exp_wdata, 32'd7);
        chk("t2_act", err_act_wdata, 32'd8);
        ev("t2e2", 4'hF, 32'h1c00_0020, 5'd9, 32'd1);
        chk("t2_hold_act", err_act_wdata, 32'd8);
        chk("t2_ready0", ref_ready, 1'b0);

        // 3: underflow, alone and with simultaneous push
        do_reset("t3r");
        ev("t3e", 4'h1, 32'h1c00_0040, 5'd4, 32'hAB);
        chk("t3_uf", err_underflow, 1'b1);
        chk("t3_expwd0", err_exp_wdata, 32'd0);
        do_reset("t3r2");
        step("t3pe", 1'b1, 32'h1c00_0044, 5'd5, 32'd3, 4'hF, 32'h1c00_0044, 5'd5, 32'd3);
        chk("t3b_uf", err_underflow, 1'b1);
        chk("t3b_expwn0", err_exp_wnum, 5'd0);

        // 4: full FIFO, no pop-to-push bypass, non-events
        do_reset("t4r");
        for (int i = 0; i < DEPTH; i++) push("t4p", 32'h1c00_0000 + 4 * i, 5'(i + 1), 32'(i * 3));
        chk("t4_full_lvl", fifo_level, 5'd16);
        chk("t4_full_rdy", ref_ready, 1'b0);
        step("t4pe", 1'b1, 32'h1c00_0080, 5'd7, 32'd77, 4'hF, 32'h1c00_0000, 5'd1, 32'd0);
        chk("t4_no_acc", fifo_level, 5'd15);
        chk("t4_rdy_back", ref_ready, 1'b1);
        ev("t4r0", 4'hF, 32'h1c00_0004, 5'd0, 32'd3);
        ev("t4we0", 4'h0, 32'h1c00_0004, 5'd2, 32'd3);
        chk("t4_nonev", fifo_level, 5'd15);

        // 5: END_PC terminates the run
        do_reset("t5r");
        push("t5p", 32'h1c00_00fc, 5'd4, 32'd11);
        push("t5p", END_PC, 5'd5, 32'd22);
        ev("t5e", 4'hF, 32'h1c00_00fc, 5'd4, 32'd11);
        ev("t5e", 4'hF, END_PC, 5'd5, 32'd22);
        chk("t5_done", chk_done, 1'b1);
        chk("t5_cnt", match_cnt, 32'd2);
        ev("t5x", 4'hF, 32'h1c00_0200, 5'd6, 32'd99);
        push("t5xp", 32'h1c00_0204, 5'd6, 32'd1);
        chk("t5_noerr", chk_error, 1'b0);
        chk("t5_frozen", fifo_level, 5'd0);

        // 6: byte-masked compare, then reset mid-run
        do_reset("t6r");
        push("t6p", 32'h1c00_0010, 5'd6, 32'h1234_5678);
        ev("t6e", 4'b0001, 32'h1c00_0010, 5'd6, 32'hFFFF_FF78);
`ifdef TRACE_CHK_BYTE_MASK_EN
        chk("t6_mask", chk_error, 1'b0);
`else
        chk("t6_nomask", chk_error, 1'b1);
        chk("t6_actwd", err_act_wdata, 32'hFFFF_FF78);
`endif
        push("t6p2", 32'h1c00_0014, 5'd7, 32'd1);
        do_reset("t6mid");
        chk("t6_lvl0", fifo_level, 5'd0);
        chk("t6_err0", chk_error, 1'b0);
        chk("t6_cnt0", match_cnt, 32'd0);
        chk("t6_rdy1", ref_ready, 1'b1);

        // Randomized sessions against the model
        for (int s = 0; s < 8; s++) begin
            do_reset("rr");
            for (int i = 0; i < 20; i++) begin
                gl[i].pc = 32'h1c00_0000 + 4 * i;
                gl[i].wn = 5'($urandom_range(1, 31));
                gl[i].wd = $urandom;
            end
            if (s % 2 == 1) gl[19].pc = END_PC;
            pi = 0; ei = 0;
            for (int c = 0; c < 80; c++) begin
                logic        v;
                logic [3:0]  we;
                logic [31:0] pc, wd;
                logic [4:0]  wn;
                int          r;
                v = (pi < 20) && ($urandom_range(0, 1) == 1);
                we = 4'd0; pc = 32'd0; wn = 5'd0; wd = 32'd0;
                r = $urandom_range(0, 7);
                if (ei < 20 && ((r < 3 && ei < pi) || $urandom_range(0, 40) == 0)) begin
                    we = 4'($urandom_range(1, 15));
                    pc = gl[ei].pc; wn = gl[ei].wn; wd = gl[ei].wd;
                    if ($urandom_range(0, 15) == 0) wd = wd ^ 32'h0000_0001;
                    if ($urandom_range(0, 31) == 0) wn = wn ^ 5'd1;
                    ei++;
                end else if (r == 3) begin
                    we = 4'($urandom_range(0, 15));
                    pc = $urandom; wd = $urandom;
                    wn = (we == 4'd0) ? 5'($urandom_range(1, 31)) : 5'd0;
                end
                if (v && m_ready()) begin
                    step("rnd", v, gl[pi].pc, gl[pi].wn, gl[pi].wd, we, pc, wn, wd);
                    pi++;
                end else begin
                    step("rnd", v, gl[pi % 20].pc, gl[pi % 20].wn, gl[pi % 20].wd, we, pc, wn, wd);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
